mem_bus_if: RTL and testbench

//  Memory bus interface between the multicycle CPU datapath/controller and a word-wide external memory

---
 rtl/cpu_bus_pkg.sv | 21 ++
 rtl/mem_timeout_counter.sv | 37 +++
 rtl/mem_bus_if.sv | 145 ++++++++++++++
 tb/tb_mem_bus_if.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU memory bus interface: FSM states, access kinds,
// and the word substituted for read data when a bus access times out.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bus_state_e;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_READ  = 2'd1,
        KIND_WRITE = 2'd2
    } access_kind_e;

    // All-zero word decodes as a NOP in the instruction register.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive WAIT cycles and flags the cycle in which the response
// budget runs out. TIMEOUT=0 disables the flag entirely.
module mem_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int MAXV = (TIMEOUT > 0) ? TIMEOUT : 1;
    localparam int W    = $clog2(MAXV + 1);
    localparam logic [W-1:0] SAT  = W'(MAXV);
    // count_q holds WAIT cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
    localparam logic [W-1:0] LAST = W'(MAXV - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && count_q != SAT)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired = (TIMEOUT != 0) && en && (count_q == LAST);

endmodule

// File: rtl/mem_bus_if.sv
// Bridges the multicycle CPU controller strobes onto a req/gnt + rvalid memory
// bus, latching fetched words into the IR and loaded words into the MDR.
module mem_bus_if
    import cpu_bus_pkg::*;
#(
    parameter int             AW       = 32,
    parameter int             DW       = 32,
    parameter int             TIMEOUT  = 255,
    parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IRWrite,
    input  logic          IorD,
    input  logic          MemWrite,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alu_out,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] mdr,
    output logic          bus_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);
    bus_state_e   state_q, state_d;
    access_kind_e kind_q, kind_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic          we_q, we_d;
    logic          err_q, err_d;

    logic          access, is_fetch, is_write;
    logic          capture;
    logic [DW-1:0] capture_data;
    logic          expired;

    assign access   = IRWrite | IorD;
    assign is_fetch = IRWrite & ~IorD;
    assign is_write = IorD & MemWrite;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != ST_WAIT),
        .en      (state_q == ST_WAIT),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        instr_d      = instr_q;
        mdr_d        = mdr_q;
        err_d        = err_q;
        capture      = 1'b0;
        capture_data = mem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    addr_d  = (IorD ? alu_out : pc) & ~AW'(3);
                    we_d    = is_write;
                    wdata_d = wdata;
                    kind_d  = is_fetch ? KIND_FETCH : (is_write ? KIND_WRITE : KIND_READ);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        capture = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A response arriving in the expiry cycle still wins over the error.
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (expired) begin
                    capture      = 1'b1;
                    capture_data = ERR_DATA;
                    err_d        = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            case (kind_q)
                KIND_FETCH: instr_d = capture_data;
                KIND_READ:  mdr_d   = capture_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    assign stall     = ((state_q == ST_IDLE) & access) | (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign instr     = instr_q;
    assign mdr       = mdr_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: plays the memory side of the handshake and
// checks bus signals, stall length and IR/MDR capture against hand values.
module tb_mem_bus_if;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk, rst;
    logic          IRWrite, IorD, MemWrite;
    logic [AW-1:0] pc, alu_out;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] instr, mdr;
    logic          bus_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_if #(.AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .pc         (pc),
        .alu_out    (alu_out),
        .wdata      (wdata),
        .stall      (stall),
        .instr      (instr),
        .mdr        (mdr),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one access from IDLE and answers it: gnt after gnt_wait extra REQ
    // cycles, rvalid in WAIT cycle rv_wait (rv_wait<0 never answers), or gnt+rvalid
    // together when same=1. Returns in the cycle after DONE (back in IDLE).
    task automatic run_access(
        input  logic        irw, iord, mw,
        input  logic [31:0] pc_i, alu_i, wd_i,
        input  int          gnt_wait, rv_wait,
        input  logic        same,
        input  logic [31:0] rd,
        output int          stall_cyc,
        output int          req_cyc,
        output logic        addr_stable,
        output logic [31:0] seen_addr,
        output logic        seen_we,
        output logic [31:0] seen_wdata
    );
        int  n_wait;
        logic done;
        IRWrite = irw; IorD = iord; MemWrite = mw;
        pc = pc_i; alu_out = alu_i; wdata = wd_i;
        stall_cyc = 0; req_cyc = 0; n_wait = 0; done = 1'b0;
        addr_stable = 1'b1; seen_addr = '0; seen_we = 1'b0; seen_wdata = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stall_cyc++;
            if (mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
                end else if (mem_addr !== seen_addr || mem_we !== seen_we || mem_wdata !== seen_wdata) begin
                    addr_stable = 1'b0;
                end
                if (req_cyc > gnt_wait) begin
                    mem_gnt = 1'b1;
                    if (same) begin
                        mem_rvalid = 1'b1; mem_rdata = rd;
                    end
                end
            end else if (cyc > 0) begin
                n_wait++;
                if (rv_wait >= 0 && n_wait >= rv_wait) begin
                    mem_rvalid = 1'b1; mem_rdata = rd;
                end
            end
            @(posedge clk); #1;
        end
        if (!done) chk("access_cycle_budget", 32'd0, 32'd1);
        IRWrite = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
    endtask

    int          sc, rc;
    logic        stable, swe;
    logic [31:0] saddr, swd;

    initial begin
        rst = 1'b1; IRWrite = 0; IorD = 0; MemWrite = 0;
        pc = '0; alu_out = '0; wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: minimal fetch
        run_access(1, 0, 0, 32'h0000_3004, 32'h0, 32'h0, 0, 1, 0, 32'h2008_0005, sc, rc, stable, saddr, swe, swd);
        chk("t1_addr", saddr, 32'h0000_3004);
        chk("t1_we", {31'd0, swe}, 32'd0);
        chk("t1_instr", instr, 32'h2008_0005);
        chk("t1_stall_cycles", sc, 32'd3);
        chk("t1_mdr", mdr, 32'd0);

        // 2: fetch, gnt on 5th REQ cycle, rvalid on 3rd WAIT cycle: 1+5+3 stall cycles
        run_access(1, 0, 0, 32'h0000_3009, 32'h0, 32'h0, 4, 3, 0, 32'h8C09_0004, sc, rc, stable, saddr, swe, swd);
        chk("t2_req_cycles", rc, 32'd5);
        chk("t2_addr_stable", {31'd0, stable}, 32'd1);
        chk("t2_addr", saddr, 32'h0000_3008);
        chk("t2_stall_cycles", sc, 32'd9);
        chk("t2_instr", instr, 32'h8C09_0004);

        // 4: load with gnt and rvalid in the same cycle
        run_access(0, 1, 0, 32'h0000_3010, 32'h0000_0207, 32'h0, 0, 0, 1, 32'h1234_5678, sc, rc, stable, saddr, swe, swd);
        chk("t4_addr", saddr, 32'h0000_0204);
        chk("t4_stall_cycles", sc, 32'd2);
        chk("t4_mdr", mdr, 32'h1234_5678);
        chk("t4_instr", instr, 32'h8C09_0004);

        // 3: store
        run_access(0, 1, 1, 32'h0000_3014, 32'h0000_0102, 32'hCAFE_F00D, 0, 1, 0, 32'hDEAD_BEEF, sc, rc, stable, saddr, swe, swd);
        chk("t3_addr", saddr, 32'h0000_0100);
        chk("t3_we", {31'd0, swe}, 32'd1);
        chk("t3_wdata", swd, 32'hCAFE_F00D);
        chk("t3_mdr", mdr, 32'h1234_5678);
        chk("t3_instr", instr, 32'h8C09_0004);
        chk("t3_err", {31'd0, bus_err}, 32'd0);

        // 5: load that never answers -> 8 WAIT cycles then error
        run_access(0, 1, 0, 32'h0, 32'h0000_0200, 32'h0, 0, -1, 0, 32'h0, sc, rc, stable, saddr, swe, swd);
        chk("t5_stall_cycles", sc, 32'd10);
        chk("t5_err", {31'd0, bus_err}, 32'd1);
        chk("t5_mdr", mdr, 32'h0000_0000);
        chk("t5_instr", instr, 32'h8C09_0004);

        // bus_err stays set across a later good access
        run_access(0, 1, 0, 32'h0, 32'h0000_0040, 32'h0, 1, 2, 0, 32'h0BAD_CAFE, sc, rc, stable, saddr, swe, swd);
        chk("sticky_mdr", mdr, 32'h0BAD_CAFE);
        chk("sticky_err", {31'd0, bus_err}, 32'd1);

        // 6: reset in WAIT, then a stale rvalid
        IRWrite = 1; IorD = 0; pc = 32'h0000_0044; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        @(posedge clk); #1;
        IRWrite = 0;
        chk("t6_in_wait", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_we", {31'd0, mem_we}, 32'd0);
        chk("t6_addr", mem_addr, 32'd0);
        chk("t6_wdata", mem_wdata, 32'd0);
        chk("t6_instr", instr, 32'd0);
        chk("t6_mdr", mdr, 32'd0);
        chk("t6_err", {31'd0, bus_err}, 32'd0);
        chk("t6_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(posedge clk); #1;
        chk("t6_stale_instr", instr, 32'd0);
        chk("t6_stale_mdr", mdr, 32'd0);
        chk("t6_stale_stall", {31'd0, stall}, 32'd0);
        chk("t6_stale_req", {31'd0, mem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
